// File: rtl/gf2m_serial_multiplier.sv
// Bit-serial polynomial-basis multiplier over GF(2^M), MSB-first
// shift-and-add with interleaved reduction by f(x) = x^M + POLY.
// One operand bit is consumed per clock, so a product takes M cycles.
// Latency is the same for every operand value, including zero operands.
module gf2m_serial_multiplier #(
    parameter int unsigned  M    = 233,
    parameter logic [255:0] POLY = (256'd1 << 74) | 256'd1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] a,
    input  logic [255:0] b,
    output logic         busy,
    output logic         done,
    output logic [255:0] c
);

    // The counter walks the multiplier bits from M-1 down to 0.
    localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [M-1:0]  a_r;
    logic [M-1:0]  b_r;
    logic [M-1:0]  z;
    logic [M-1:0]  z_next;
    logic [M-1:0]  c_r;
    logic [CW-1:0] cnt;
    logic          load;
    logic          finish;

    // Operand bits above the field degree are deliberately ignored.
    if (M < 256) begin : g_ignore_upper
        logic unused_upper_bits;
        assign unused_upper_bits = ^{a[255:M], b[255:M]};
    end

    // One Horner step: z*x mod f, then add b when the current multiplier bit is set.
    always_comb begin
        z_next = {z[M-2:0], 1'b0};
        if (z[M-1]) begin
            z_next = z_next ^ POLY[M-1:0];
        end
        if (a_r[cnt]) begin
            z_next = z_next ^ b_r;
        end
    end

    // State register; reset aborts any multiplication in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: start is only honoured in IDLE, RUN ends after the bit-0 step.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture operands at start, iterate while running, publish on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r  <= '0;
            b_r  <= '0;
            z    <= '0;
            cnt  <= '0;
            c_r  <= '0;
            done <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                a_r <= a[M-1:0];
                b_r <= b[M-1:0];
                z   <= '0;
                cnt <= CW'(M - 1);
            end else if (state == RUN) begin
                z <= z_next;
                if (finish) begin
                    c_r <= z_next;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

    // Busy follows the state directly, so it is high for exactly the M RUN cycles.
    always_comb begin
        busy = (state == RUN);
    end

    // The product is zero-extended onto the full 256-bit bus.
    always_comb begin
        c        = '0;
        c[M-1:0] = c_r;
    end

endmodule

// File: tb/tb_gf2m_serial_multiplier.sv
// Self-checking bench for gf2m_serial_multiplier (M = 233, f = x^233 + x^74 + 1).
module tb_gf2m_serial_multiplier;

    localparam int unsigned  M     = 233;
    localparam logic [255:0] POLY  = (256'd1 << 74) | 256'd1;
    localparam logic [255:0] FMASK = (256'd1 << M) - 256'd1;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [255:0] a;
    logic [255:0] b;
    logic         busy;
    logic         done;
    logic [255:0] c;

    int checksRun;
    int checksPassed;

    typedef struct {
        logic [255:0] opA;
        logic [255:0] opB;
        logic [255:0] expC;
    } vector_t;

    vector_t vectors [11];

    gf2m_serial_multiplier #(
        .M    (M),
        .POLY (POLY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .c     (c)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: full carry-less product, then reduce from the top down.
    function automatic logic [255:0] gfModel(input logic [255:0] av, input logic [255:0] bv);
        logic [511:0] p;
        p = '0;
        for (int i = 0; i < int'(M); i++) begin
            if (av[i]) p = p ^ ({256'd0, bv & FMASK} << i);
        end
        for (int i = 2 * int'(M) - 2; i >= int'(M); i--) begin
            if (p[i]) begin
                p[i] = 1'b0;
                p    = p ^ ({256'd0, POLY} << (i - int'(M)));
            end
        end
        return p[255:0];
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checksRun++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Issue one start and watch M+5 cycles, recording busy length, done pulses and result.
    task automatic applyStimulus(input logic [255:0] av, input logic [255:0] bv,
                                 output logic [255:0] cv, output logic [255:0] cAtStart,
                                 output int busyCycles, output int doneCount, output int doneIdx);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        cAtStart   = c;
        cv         = '0;
        busyCycles = 0;
        doneCount  = 0;
        doneIdx    = -1;
        for (int i = 0; i < int'(M) + 5; i++) begin
            if (i == 1) begin
                a = ~av;
                b = ~bv;
            end
            if (busy) busyCycles++;
            if (done) begin
                doneCount++;
                doneIdx = i;
                cv      = c;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [255:0] res;
        logic [255:0] cStart;
        logic [255:0] prevC;
        logic [255:0] ra;
        logic [255:0] rb;
        int busyCycles;
        int doneCount;
        int doneIdx;
        int seenIdx;

        checksRun    = 0;
        checksPassed = 0;

        vectors[0]  = '{256'h1, 256'h1234_5678, 256'h1234_5678};
        vectors[1]  = '{256'h2, 256'd1 << 232, (256'd1 << 74) | 256'd1};
        vectors[2]  = '{(256'd1 << 255) | 256'd1, 256'hABCD, 256'hABCD};
        vectors[3]  = '{256'h3, 256'h3, 256'h5};
        vectors[4]  = '{256'h0, {256{1'b1}}, 256'h0};
        vectors[5]  = '{{256{1'b1}}, 256'h0, 256'h0};
        vectors[6]  = '{256'd1 << 232, 256'd1 << 232, (256'd1 << 231) | (256'd1 << 146) | (256'd1 << 72)};
        vectors[7]  = '{256'd1 << 100, 256'd1 << 200, (256'd1 << 141) | (256'd1 << 67)};
        vectors[8]  = '{256'h3, 256'd1 << 232, (256'd1 << 232) | (256'd1 << 74) | 256'd1};
        vectors[9]  = '{256'hABCD, 256'h1, 256'hABCD};
        vectors[10] = '{256'h1, (256'd1 << 240) | 256'h55, 256'h55};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {255'd0, busy}, 256'd0);
        checkOutput("reset_done", {255'd0, done}, 256'd0);
        checkOutput("reset_c", c, 256'd0);
        rst_n = 1'b1;

        prevC = '0;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vectors[i].opA, vectors[i].opB, res, cStart, busyCycles, doneCount, doneIdx);
            checkOutput($sformatf("vec%0d_c", i), res, vectors[i].expC);
            checkOutput($sformatf("vec%0d_busy_cycles", i), 256'(busyCycles), 256'(M));
            checkOutput($sformatf("vec%0d_done_pulses", i), 256'(doneCount), 256'd1);
            checkOutput($sformatf("vec%0d_done_index", i), 256'(doneIdx), 256'(M));
            checkOutput($sformatf("vec%0d_c_held_at_start", i), cStart, prevC);
            prevC = vectors[i].expC;
        end

        for (int n = 0; n < 24; n++) begin
            for (int k = 0; k < 8; k++) begin
                ra[32*k +: 32] = $urandom();
                rb[32*k +: 32] = $urandom();
            end
            applyStimulus(ra, rb, res, cStart, busyCycles, doneCount, doneIdx);
            checkOutput($sformatf("rand%0d_c", n), res, gfModel(ra, rb));
        end

        // Start during RUN is ignored; then a start on the done cycle is accepted.
        @(negedge clk);
        a     = 256'h1;
        b     = 256'h1111;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        seenIdx = -1;
        for (int i = 0; i < int'(M) + 5 && seenIdx < 0; i++) begin
            if (i >= 100) begin
                a     = 256'h1;
                b     = 256'h2222;
                start = (i == 100);
            end
            if (done) begin
                seenIdx = i;
                checkOutput("midrun_c", c, 256'h1111);
                a     = 256'h3;
                b     = 256'h3;
                start = 1'b1;
            end
            @(negedge clk);
        end
        checkOutput("midrun_done_index", 256'(seenIdx), 256'(M));
        start = 1'b0;
        checkOutput("b2b_busy_after_done_start", {255'd0, busy}, 256'd1);
        seenIdx = -1;
        for (int i = 0; i < int'(M) + 5 && seenIdx < 0; i++) begin
            if (done) begin
                seenIdx = i;
                checkOutput("b2b_c", c, 256'h5);
            end
            @(negedge clk);
        end
        checkOutput("b2b_done_index", 256'(seenIdx), 256'(M));

        // Reset in the middle of a run clears everything without a done pulse.
        @(negedge clk);
        a     = 256'hABCD;
        b     = 256'h1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {255'd0, busy}, 256'd0);
        checkOutput("abort_done", {255'd0, done}, 256'd0);
        checkOutput("abort_c", c, 256'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(256'h3, 256'h3, res, cStart, busyCycles, doneCount, doneIdx);
        checkOutput("after_abort_c", res, 256'h5);
        checkOutput("after_abort_c_at_start", cStart, 256'd0);
        checkOutput("after_abort_busy_cycles", 256'(busyCycles), 256'(M));
        checkOutput("after_abort_done_pulses", 256'(doneCount), 256'd1);

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
